// File: rtl/uart_wb_bridge_pkg.sv
// uart_wb_bridge_pkg: command codes and FSM state encoding shared by the bridge
package uart_wb_bridge_pkg;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RESP_WACK = 8'h06;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
endpackage

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: parses UART command packets into single Wishbone transactions
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int TO_WIDTH = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_stb,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ack,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic [DW-1:0] wb_rdata,
  input  logic          wb_ack,
  output logic          err_stb
);
  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  state_t state;
  logic [7:0] cnt;
  logic [TO_WIDTH-1:0] to;
  logic is_wr;
  logic [DW-1:0] rsp;
  // response bytes leave from the top of a shift register
  assign tx_data = rsp[DW-1 -: 8];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      to       <= '0;
      is_wr    <= 1'b0;
      rsp      <= '0;
      tx_valid <= 1'b0;
      wb_addr  <= '0;
      wb_wdata <= '0;
      wb_we    <= 1'b0;
      wb_cyc   <= 1'b0;
      err_stb  <= 1'b0;
    end else begin
      err_stb <= 1'b0;
      to <= (rx_stb || !(state == ADDR || state == DATA)) ? '0 : to + 1'b1;
      case (state)
        IDLE: if (rx_stb) begin
          if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
            state <= ADDR;
            cnt   <= 8'(AB - 1);
            is_wr <= rx_data == CMD_WRITE;
          end else err_stb <= 1'b1;
        end
        ADDR, DATA: if (rx_stb) begin
          if (state == ADDR) wb_addr <= AW'({wb_addr, rx_data});
          else wb_wdata <= DW'({wb_wdata, rx_data});
          cnt <= cnt - 1'b1;
          if (cnt == 0) begin
            if (state == ADDR && is_wr) begin
              state <= DATA;
              cnt   <= 8'(DB - 1);
            end else begin
              state  <= BUS;
              wb_cyc <= 1'b1;
              wb_we  <= is_wr;
            end
          end
        end else if (&to) begin
          state   <= IDLE;
          err_stb <= 1'b1;
        end
        BUS: begin
          err_stb <= rx_stb;
          if (wb_ack) begin
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            tx_valid <= 1'b1;
            state    <= RESP;
            rsp      <= is_wr ? DW'(RESP_WACK) << (DW - 8) : wb_rdata;
            cnt      <= is_wr ? 8'd0 : 8'(DB - 1);
          end
        end
        RESP: begin
          err_stb <= rx_stb;
          if (tx_ack) begin
            rsp <= rsp << 8;
            cnt <= cnt - 1'b1;
            if (cnt == 0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: scoreboard bench with a packet-level reference model
module tb_uart_wb_bridge;
  localparam int AW = 16, DW = 32, TOW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data, tx_data;
  logic rx_stb, tx_valid, tx_ack;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata, wb_rdata;
  logic wb_we, wb_cyc, wb_ack, err_stb;
  int compared = 0, mismatched = 0;
  typedef struct {logic [15:0] a; logic [31:0] d; logic we;} wb_op_t;
  wb_op_t exp_wb[$];
  logic [7:0] exp_tx[$];
  logic [31:0] ref_mem[logic [15:0]];
  logic [31:0] slv_mem[logic [15:0]];
  int exp_err = 0, err_seen = 0, stall = -1, slv_dly = -1;

  uart_wb_bridge #(.AW(AW), .DW(DW), .TO_WIDTH(TOW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_rdata(wb_rdata), .wb_ack(wb_ack), .err_stb(err_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Wishbone slave backed by its own memory
  initial begin
    int cnt, dly;
    cnt = 0; dly = 0;
    wb_ack = 1'b0; wb_rdata = '0;
    forever begin
      @(posedge clk); #1;
      wb_ack = 1'b0;
      if (rst) cnt = 0;
      else if (wb_cyc) begin
        if (cnt == 0) dly = slv_dly >= 0 ? slv_dly : int'($urandom_range(0, 4));
        if (cnt >= dly) begin
          wb_ack = 1'b1;
          wb_rdata = wb_we ? $urandom : (slv_mem.exists(wb_addr) ? slv_mem[wb_addr] : dflt(wb_addr));
          if (wb_we) slv_mem[wb_addr] = wb_wdata;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // TX consumer with programmable or random stall
  initial begin
    int vc, cur;
    vc = 0; cur = 0;
    tx_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ack = 1'b0;
      if (rst) vc = 0;
      else if (tx_valid) begin
        if (vc == 0) cur = stall >= 0 ? stall : int'($urandom_range(0, 3));
        if (vc >= cur) begin
          tx_ack = 1'b1;
          vc = 0;
        end else vc++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or starts a bus cycle
  initial begin
    logic cyc_q, ack_q, err_q;
    logic [15:0] a_q;
    wb_op_t op;
    cyc_q = 0; ack_q = 0; err_q = 0; a_q = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc_q = 0; ack_q = 0; err_q = 0;
      end else begin
        if (tx_valid && tx_ack) begin
          if (exp_tx.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL tx_unexpected: got %h expected none", tx_data);
          end else chk("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (wb_cyc && !cyc_q) begin
          if (exp_wb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL wb_unexpected: got addr %h expected no cycle", wb_addr);
          end else begin
            op = exp_wb.pop_front();
            chk("wb_addr", wb_addr, op.a);
            chk("wb_we", wb_we, op.we);
            if (op.we) chk("wb_wdata", wb_wdata, op.d);
          end
        end
        if (wb_cyc && cyc_q) chk("wb_addr_stable", wb_addr, a_q);
        if (ack_q) begin
          chk("cyc_after_ack", wb_cyc, 0);
          chk("tx_valid_after_ack", tx_valid, 1);
        end
        if (err_stb && err_q) chk("err_single_cycle", 1, 0);
        if (err_stb) err_seen++;
        cyc_q = wb_cyc; ack_q = wb_cyc && wb_ack; err_q = err_stb; a_q = wb_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    exp_wb.push_back('{a, d, 1'b1});
    exp_tx.push_back(8'h06);
    ref_mem[a] = d;
    send(8'h02); send(a[15:8]); send(a[7:0]);
    for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
  endtask

  task automatic do_read(input logic [15:0] a);
    logic [31:0] v;
    v = ref_rd(a);
    exp_wb.push_back('{a, 32'h0, 1'b0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
    send(8'h01); send(a[15:8]); send(a[7:0]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || tx_valid || wb_cyc) && n < 2000) begin
      tick();
      n++;
    end
    compared++;
    if (n >= 2000) begin
      mismatched++;
      $display("FAIL %s_timeout: got %0d pending bytes expected 0", name, exp_tx.size());
      exp_tx.delete(); exp_wb.delete();
    end
    repeat (2) tick();
  endtask

  task automatic wait_for(input string name, input bit want_cyc);
    int n;
    n = 0;
    while (!(want_cyc ? wb_cyc : tx_valid) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      compared++; mismatched++;
      $display("FAIL %s: got no event expected one within 500 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected one before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_stb = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_cyc", wb_cyc, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_err_stb", err_stb, 0);
    rst = 1'b0;
    tick();
    do_write(16'h1234, 32'hDEADBEEF);
    wait_done("write");
    chk("err_after_write", err_seen, exp_err);
    slv_mem[16'h0010] = 32'hCAFEF00D;
    ref_mem[16'h0010] = 32'hCAFEF00D;
    slv_dly = 3; stall = 5;
    do_read(16'h0010);
    wait_done("read_stall");
    slv_dly = -1; stall = -1;
    send(8'h55); exp_err++;
    do_read(16'h1234);
    wait_done("bad_cmd_read");
    chk("err_bad_cmd", err_seen, exp_err);
    send(8'h02); send(8'h12);
    exp_err++;
    repeat ((1 << TOW) + 40) tick();
    chk("err_timeout", err_seen, exp_err);
    do_read(16'h0010);
    wait_done("read_after_timeout");
    slv_dly = 4; stall = 5;
    do_read(16'h1234);
    wait_for("wait_bus", 1'b1);
    send(8'hAA); exp_err++;
    wait_for("wait_resp", 1'b0);
    send(8'hBB); exp_err++;
    wait_done("drop_read");
    chk("err_drop", err_seen, exp_err);
    slv_dly = 20; stall = -1;
    do_read(16'h0010);
    wait_for("wait_bus_rst", 1'b1);
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    chk("rst_async_cyc", wb_cyc, 0);
    chk("rst_async_tx_valid", tx_valid, 0);
    exp_tx.delete();
    tick();
    rst = 1'b0;
    slv_dly = -1;
    tick();
    do_read(16'h1234);
    wait_done("read_after_rst");
    for (int k = 0; k < 24; k++) begin
      logic [15:0] a;
      a = 16'h0100 + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        send(8'h80 | 8'($urandom_range(0, 127)));
        exp_err++;
      end
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else do_read(a);
      wait_done("random");
    end
    chk("err_final", err_seen, exp_err);
    chk("wb_queue_empty", exp_wb.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
